// File: rtl/pattern_ack_handler.sv
// Acknowledges pattern-detector matches: counts/timestamps them, raises irq, re-arms detector.
// Latency: ack falls 1 cycle after found_pattern is sampled; held low >= ACK_LOW_CYCLES cycles.
// Backpressure: detector is held (ack=0) until host clears irq or the optional timeout expires.
module pattern_ack_handler #(
    parameter int ACK_LOW_CYCLES = 4,
    parameter int CNT_WIDTH      = 8,
    parameter int TS_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset_sync,
    input  logic                 found_pattern,
    input  logic                 irq_clear,
    output logic                 ack,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 count_sat,
    output logic [TS_WIDTH-1:0]  last_timestamp,
    output logic                 timeout_flag,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_CLR, REARM} state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]           HOLD_LAST = 8'(ACK_LOW_CYCLES - 1);
    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    state_t               state, state_nxt;
    logic [TS_WIDTH-1:0]  ts_cnt;
    logic [7:0]           hold_cnt, hold_nxt;
    logic [TO_W-1:0]      to_cnt, to_nxt;
    logic                 clr_pending, clr_pend_nxt;
    logic                 irq_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 sat_nxt;
    logic [TS_WIDTH-1:0]  ts_last_nxt;
    logic                 tflag_nxt;

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        to_nxt       = to_cnt;
        clr_pend_nxt = clr_pending;
        irq_nxt      = irq;
        cnt_nxt      = match_count;
        sat_nxt      = count_sat;
        ts_last_nxt  = last_timestamp;
        tflag_nxt    = timeout_flag;

        case (state)
            IDLE: begin
                // A detection takes priority over a coincident clear.
                if (found_pattern) begin
                    state_nxt    = HOLD;
                    irq_nxt      = 1'b1;
                    hold_nxt     = '0;
                    clr_pend_nxt = 1'b0;
                    ts_last_nxt  = ts_cnt;
                    if (match_count != CNT_MAX) begin
                        cnt_nxt = match_count + 1'b1;
                    end
                    if (cnt_nxt == CNT_MAX) begin
                        sat_nxt = 1'b1;
                    end
                end else if (irq_clear) begin
                    irq_nxt = 1'b0;
                end
            end
            HOLD: begin
                hold_nxt = hold_cnt + 8'd1;
                if (irq_clear) begin
                    clr_pend_nxt = 1'b1;
                    irq_nxt      = 1'b0;
                end
                if (hold_cnt == HOLD_LAST) begin
                    to_nxt    = '0;
                    state_nxt = (clr_pending || irq_clear) ? REARM : WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (irq_clear) begin
                    irq_nxt   = 1'b0;
                    state_nxt = REARM;
                end else if ((TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST)) begin
                    state_nxt = REARM;
                    tflag_nxt = 1'b1;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            REARM: begin
                if (irq_clear) begin
                    irq_nxt = 1'b0;
                end
                if (!found_pattern) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            state          <= IDLE;
            ts_cnt         <= '0;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            clr_pending    <= 1'b0;
            ack            <= 1'b1;
            irq            <= 1'b0;
            match_count    <= '0;
            count_sat      <= 1'b0;
            last_timestamp <= '0;
            timeout_flag   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            ts_cnt         <= ts_cnt + 1'b1;
            hold_cnt       <= hold_nxt;
            to_cnt         <= to_nxt;
            clr_pending    <= clr_pend_nxt;
            ack            <= (state_nxt == IDLE) || (state_nxt == REARM);
            irq            <= irq_nxt;
            match_count    <= cnt_nxt;
            count_sat      <= sat_nxt;
            last_timestamp <= ts_last_nxt;
            timeout_flag   <= tflag_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/pattern_ack_handler.md
Name: pattern_ack_handler

Overview:
- Downstream consumer of the 4-byte pattern detector's found_pattern output.
- Drives the detector's ack input to acknowledge and re-arm it.
- Counts and timestamps matches, and raises a level interrupt to the host.
- Holds the detector in its post-match state until the host clears the interrupt (or an optional timeout expires), then re-arms it.

Parameters:
ACK_LOW_CYCLES, 4, minimum cycles ack is held low after a match; legal range 1..255
CNT_WIDTH, 8, width of the saturating match counter
TS_WIDTH, 16, width of the free-running timestamp counter
TIMEOUT_CYCLES, 0, cycles in WAIT_CLR before automatic re-arm; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
reset_sync  in  1  asynchronous active-low reset
found_pattern  in  1  registered match flag from the pattern detector
irq_clear  in  1  host clear pulse, single cycle, active high
ack  out  1  acknowledge/arm to the detector; 1 = armed
irq  out  1  match interrupt, level
match_count  out  CNT_WIDTH  number of matches since reset, saturating
count_sat  out  1  sticky; set when match_count reaches all-ones
last_timestamp  out  TS_WIDTH  timestamp counter value latched at the last match
timeout_flag  out  1  sticky; set when a re-arm was forced by timeout
busy  out  1  high in every state except IDLE

Behaviour:
Reset values (while reset_sync=0, asynchronous):
- ack=1, so the detector can arm immediately after reset.
- irq=0, match_count=0, count_sat=0, last_timestamp=0, timeout_flag=0, busy=0.
- State=IDLE; timestamp counter, hold counter, timeout counter and clr_pending all 0.

Timestamp counter:
- Increments every cycle; wraps from all-ones to 0.

State machine (all outputs registered):
- IDLE, ack=1:
  - On found_pattern=1 go to HOLD.
  - On that same edge: ack<=0; irq<=1; match_count += 1, saturating at all-ones, with count_sat<=1 when the new value is all-ones; last_timestamp<=current timestamp; hold counter<=0; clr_pending<=0.
- HOLD, ack=0:
  - Hold counter increments each cycle.
  - An irq_clear pulse sets clr_pending and clears irq.
  - When the hold counter reaches ACK_LOW_CYCLES-1: go to REARM if clr_pending=1 or irq_clear=1 this cycle; otherwise go to WAIT_CLR.
- WAIT_CLR, ack=0:
  - On irq_clear=1: irq<=0 and go to REARM.
  - If TIMEOUT_CYCLES>0 and the timeout counter reaches TIMEOUT_CYCLES-1 with no clear: go to REARM, timeout_flag<=1, irq stays 1.
  - If irq_clear and the timeout occur on the same cycle, the clear wins: timeout_flag is not set.
- REARM, ack=1:
  - Wait for found_pattern=0, then go to IDLE.
  - The detector drops found_pattern on the edge it samples ack=1, so REARM normally lasts 1 cycle.

Latency and ack timing:
- ack falls 1 cycle after found_pattern is first sampled high.
- ack stays low for at least ACK_LOW_CYCLES cycles.
- The detector sees at least one low sample of ack, so it always leaves its B2 state.

irq_clear rules:
- irq_clear in IDLE or REARM clears irq; it does not affect the state.
- irq_clear in the same cycle as a detection in IDLE is ignored; the new match sets irq=1.

Matches and saturation:
- A match is counted only on an IDLE->HOLD transition.
- found_pattern staying high does not re-count.
- match_count holds at all-ones; count_sat stays 1 until reset.

Reset mid-operation:
- Any state returns to IDLE with the reset values above.
- ack=1 immediately (asynchronous).

Test Plan:
1. Reset release, no found_pattern for 10 cycles -> ack=1, irq=0, busy=0, match_count=0.
2. found_pattern high at the timestamp counter's value 0x0020, irq_clear pulsed 10 cycles later, ACK_LOW_CYCLES=4 -> ack=0 for exactly 10 cycles; irq falls the cycle after irq_clear; last_timestamp=0x0020; match_count=1; found_pattern falls 1 cycle after ack rises.
3. irq_clear pulsed on the 2nd HOLD cycle, ACK_LOW_CYCLES=4 -> irq clears immediately; ack still low for exactly 4 cycles, then re-arms with no second clear needed.
4. TIMEOUT_CYCLES=8, no irq_clear -> ack low for 4+8 cycles, then ack=1, timeout_flag=1, irq stays 1 until a later irq_clear.
5. CNT_WIDTH=2, 5 back-to-back matches each cleared -> match_count sequence 1,2,3,3,3; count_sat=1 from the 3rd match.
6. reset_sync driven low during WAIT_CLR -> ack=1, irq=0, match_count=0 asynchronously; the next match is counted as 1.
